// File: rtl/buffer_a_nx.sv
// Multi-buffer matrix staging store: a matrix is loaded one element per cycle
// and replayed one column per cycle onto a wide, zero-masked lane bus.
module buffer_a_nx #(
  parameter int VAR_SIZE = 8,
  parameter int MMU_SIZE = 10,
  parameter int NUM_BUF  = 16,
  parameter int BUF_W    = 5
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                stop,
  input  logic [1:0]                          cmd,
  input  logic [BUF_W-1:0]                    buffer,
  input  logic signed [VAR_SIZE-1:0]          A,
  input  logic [7:0]                          dim_x_in,
  input  logic [7:0]                          dim_y_in,
  output logic signed [VAR_SIZE*MMU_SIZE-1:0] B1,
  output logic                                B1_valid,
  output logic                                busy,
  output logic                                done,
  output logic                                err,
  output logic [7:0]                          dim_x_out,
  output logic [7:0]                          dim_y_out
);

  localparam int         IDX_W   = (NUM_BUF > 1) ? $clog2(NUM_BUF) : 1;
  localparam int         PTR_W   = (MMU_SIZE > 1) ? $clog2(MMU_SIZE) : 1;
  localparam logic [7:0] MAX_DIM = 8'(MMU_SIZE);

  localparam logic [1:0] CMD_LOAD  = 2'b01;
  localparam logic [1:0] CMD_SEND  = 2'b10;
  localparam logic [1:0] CMD_CLEAR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SEND  = 2'd2,
    S_CLEAR = 2'd3
  } state_e;

  // One column of a buffer; lane r sits at bits [r*VAR_SIZE +: VAR_SIZE].
  typedef logic [MMU_SIZE-1:0][VAR_SIZE-1:0] column_t;

  state_e           state_q, state_d;
  logic [PTR_W-1:0] row_q, row_d;
  logic [PTR_W-1:0] col_q, col_d;
  logic [IDX_W-1:0] buf_q, buf_d;
  logic [7:0]       dim_x_q [NUM_BUF];
  logic [7:0]       dim_x_d [NUM_BUF];
  logic [7:0]       dim_y_q [NUM_BUF];
  logic [7:0]       dim_y_d [NUM_BUF];
  column_t          b1_q, b1_d;
  logic             b1_valid_q, b1_valid_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [7:0]       dim_x_out_q, dim_x_out_d;
  logic [7:0]       dim_y_out_q, dim_y_out_d;

  column_t          mem_q [NUM_BUF][MMU_SIZE];
  column_t          send_col;
  logic             wr_en, clr_en;
  logic             buf_ok, cmd_bad;
  logic [IDX_W-1:0] in_idx;
  logic [7:0]       cur_dim_x, cur_dim_y;

  assign in_idx    = buffer[IDX_W-1:0];
  assign buf_ok    = 32'(buffer) < NUM_BUF;
  assign cur_dim_x = dim_x_q[buf_q];
  assign cur_dim_y = dim_y_q[buf_q];

  always_comb begin
    cmd_bad = 1'b0;
    case (cmd)
      CMD_LOAD:  cmd_bad = !buf_ok || dim_x_in == 8'd0 || dim_x_in > MAX_DIM ||
                           dim_y_in == 8'd0 || dim_y_in > MAX_DIM;
      CMD_SEND:  cmd_bad = !buf_ok || dim_y_q[in_idx] == 8'd0;
      CMD_CLEAR: cmd_bad = !buf_ok;
      default:   cmd_bad = 1'b0;
    endcase
  end

  // Rows at or beyond the stored height may hold stale data and are masked.
  always_comb begin
    send_col = mem_q[buf_q][col_q];
    for (int r = 0; r < MMU_SIZE; r++) begin
      if (8'(r) >= cur_dim_x) send_col[r] = '0;
    end
  end

  // NOTE: every signal written below gets a default first so no path leaves
  // one unassigned; an unassigned path in always_comb infers a latch.
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    buf_d       = buf_q;
    dim_x_d     = dim_x_q;
    dim_y_d     = dim_y_q;
    b1_d        = stop ? b1_q : '0;
    b1_valid_d  = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    wr_en       = 1'b0;
    clr_en      = 1'b0;
    dim_x_out_d = buf_ok ? dim_x_q[in_idx] : 8'd0;
    dim_y_out_d = buf_ok ? dim_y_q[in_idx] : 8'd0;

    if (stop && cmd == CMD_CLEAR) begin
      // Abort whatever is running and wipe the latched buffer from column 0.
      state_d          = S_CLEAR;
      row_d            = '0;
      col_d            = '0;
      dim_x_d[buf_q]   = 8'd0;
      dim_y_d[buf_q]   = 8'd0;
    end else if (!stop) begin
      case (state_q)
        S_IDLE: begin
          if (cmd != 2'b00) begin
            if (cmd_bad) begin
              err_d = 1'b1;
            end else begin
              buf_d = in_idx;
              row_d = '0;
              col_d = '0;
              case (cmd)
                CMD_LOAD: begin
                  state_d         = S_LOAD;
                  dim_x_d[in_idx] = dim_x_in;
                  dim_y_d[in_idx] = dim_y_in;
                end
                CMD_SEND: state_d = S_SEND;
                default: begin
                  state_d         = S_CLEAR;
                  dim_x_d[in_idx] = 8'd0;
                  dim_y_d[in_idx] = 8'd0;
                end
              endcase
            end
          end
        end
        S_LOAD: begin
          wr_en = 1'b1;
          if (8'(row_q) == cur_dim_x - 8'd1) begin
            row_d = '0;
            if (8'(col_q) == cur_dim_y - 8'd1) begin
              col_d   = '0;
              state_d = S_IDLE;
              done_d  = 1'b1;
            end else begin
              col_d = col_q + PTR_W'(1);
            end
          end else begin
            row_d = row_q + PTR_W'(1);
          end
        end
        S_SEND: begin
          b1_d       = send_col;
          b1_valid_d = 1'b1;
          if (8'(col_q) == cur_dim_y - 8'd1) begin
            col_d   = '0;
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            col_d = col_q + PTR_W'(1);
          end
        end
        default: begin
          clr_en = 1'b1;
          if (col_q == PTR_W'(MMU_SIZE - 1)) begin
            col_d   = '0;
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            col_d = col_q + PTR_W'(1);
          end
        end
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      row_q       <= '0;
      col_q       <= '0;
      buf_q       <= '0;
      dim_x_q     <= '{default: '0};
      dim_y_q     <= '{default: '0};
      b1_q        <= '0;
      b1_valid_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      dim_x_out_q <= 8'd0;
      dim_y_out_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      buf_q       <= buf_d;
      dim_x_q     <= dim_x_d;
      dim_y_q     <= dim_y_d;
      b1_q        <= b1_d;
      b1_valid_q  <= b1_valid_d;
      done_q      <= done_d;
      err_q       <= err_d;
      dim_x_out_q <= dim_x_out_d;
      dim_y_out_q <= dim_y_out_d;
    end
  end

  // NOTE: the storage array has no reset; cleared dimensions and lane masking
  // keep stale contents from ever reaching B1, and it stays a plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[buf_q][col_q][row_q] <= A;
    end else if (clr_en) begin
      mem_q[buf_q][col_q] <= '0;
    end
  end

  assign B1        = b1_q;
  assign B1_valid  = b1_valid_q;
  assign busy      = state_q != S_IDLE;
  assign done      = done_q;
  assign err       = err_q;
  assign dim_x_out = dim_x_out_q;
  assign dim_y_out = dim_y_out_q;

endmodule

// File: tb/tb_buffer_a_nx.sv
// Self-checking bench for buffer_a_nx: directed scenarios with literal
// expectations plus randomized traffic compared every cycle to a matrix model.
module tb_buffer_a_nx;

  localparam int VS = 8;
  localparam int MS = 10;
  localparam int NB = 16;
  localparam int BW = 5;
  localparam int LW = VS * MS;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 stop = 1'b0;
  logic [1:0]           cmd = 2'b00;
  logic [BW-1:0]        buffer = '0;
  logic signed [VS-1:0] A = '0;
  logic [7:0]           dim_x_in = 8'd0;
  logic [7:0]           dim_y_in = 8'd0;
  logic signed [LW-1:0] B1;
  logic                 B1_valid, busy, done, err;
  logic [7:0]           dim_x_out, dim_y_out;
  logic [LW-1:0]        b1_u;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;

  assign b1_u = B1;

  buffer_a_nx #(.VAR_SIZE(VS), .MMU_SIZE(MS), .NUM_BUF(NB), .BUF_W(BW)) dut (
    .clk(clk), .rst_n(rst_n), .stop(stop), .cmd(cmd), .buffer(buffer), .A(A),
    .dim_x_in(dim_x_in), .dim_y_in(dim_y_in), .B1(B1), .B1_valid(B1_valid),
    .busy(busy), .done(done), .err(err), .dim_x_out(dim_x_out), .dim_y_out(dim_y_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: matrices as int arrays ----------------
  int            m_op, m_k, m_buf, mdx, mdy;
  int            m_dx [NB];
  int            m_dy [NB];
  int            m_mem [NB][MS][MS];
  logic [LW-1:0] e_b1, n_b1;
  logic          e_valid, e_done, e_err, n_valid, n_done, n_err;
  logic [7:0]    e_dxo, e_dyo, n_dxo, n_dyo;
  bit            bad;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_op = 0; m_k = 0; m_buf = 0;
      foreach (m_dx[i]) begin m_dx[i] = 0; m_dy[i] = 0; end
      e_b1 = '0; e_valid = 0; e_done = 0; e_err = 0; e_dxo = 0; e_dyo = 0;
    end else begin
      n_b1 = stop ? e_b1 : '0;
      n_valid = 0; n_done = 0; n_err = 0;
      n_dxo = (buffer < NB) ? 8'(m_dx[buffer]) : 8'd0;
      n_dyo = (buffer < NB) ? 8'(m_dy[buffer]) : 8'd0;
      mdx = m_dx[m_buf];
      mdy = m_dy[m_buf];
      if (stop && cmd == 2'b11) begin
        m_op = 3; m_k = 0; m_dx[m_buf] = 0; m_dy[m_buf] = 0;
      end else if (!stop) begin
        case (m_op)
          0: if (cmd != 2'b00) begin
            if (buffer >= NB) bad = 1;
            else if (cmd == 2'b01)
              bad = dim_x_in < 1 || dim_x_in > MS || dim_y_in < 1 || dim_y_in > MS;
            else if (cmd == 2'b10) bad = (m_dy[buffer] == 0);
            else bad = 0;
            if (bad) n_err = 1;
            else begin
              m_op = int'(cmd); m_buf = int'(buffer); m_k = 0;
              if (cmd == 2'b01) begin m_dx[m_buf] = dim_x_in; m_dy[m_buf] = dim_y_in; end
              if (cmd == 2'b11) begin m_dx[m_buf] = 0; m_dy[m_buf] = 0; end
            end
          end
          1: begin
            m_mem[m_buf][m_k / mdx][m_k % mdx] = int'(A);
            m_k++;
            if (m_k == mdx * mdy) begin m_op = 0; n_done = 1; end
          end
          2: begin
            for (int r = 0; r < MS; r++)
              n_b1[r*VS +: VS] = (r < mdx) ? VS'(m_mem[m_buf][m_k][r]) : '0;
            n_valid = 1;
            m_k++;
            if (m_k == mdy) begin m_op = 0; n_done = 1; end
          end
          default: begin
            for (int r = 0; r < MS; r++) m_mem[m_buf][m_k][r] = 0;
            m_k++;
            if (m_k == MS) begin m_op = 0; n_done = 1; end
          end
        endcase
      end
      e_b1 = n_b1; e_valid = n_valid; e_done = n_done; e_err = n_err;
      e_dxo = n_dxo; e_dyo = n_dyo;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("cyc_B1", b1_u, e_b1);
      check("cyc_B1_valid", B1_valid, e_valid);
      check("cyc_busy", busy, m_op != 0);
      check("cyc_done", done, e_done);
      check("cyc_err", err, e_err);
      check("cyc_dim_x_out", dim_x_out, e_dxo);
      check("cyc_dim_y_out", dim_y_out, e_dyo);
    end
  end

  // ---------------- directed helpers ----------------
  logic [LW-1:0] got_cols[$];
  int            send_done_col, stall_valid, stall_hold_bad, done_at, n;
  bit            done_seen;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] c, input int b, input int dx, input int dy);
    cmd = c; buffer = BW'(b); dim_x_in = 8'(dx); dim_y_in = 8'(dy);
    tick();
    cmd = 2'b00;
  endtask

  task automatic do_load(input int b, input int dx, input int dy, input int first,
                         input int step, output int first_done);
    issue(2'b01, b, dx, dy);
    first_done = -1;
    for (int i = 0; i < dx * dy; i++) begin
      A = VS'(first + i * step);
      tick();
      if (done && first_done < 0) first_done = i + 1;
    end
  endtask

  task automatic do_send(input int b, input int stall_at, input int stall_len);
    int stalled;
    stalled = 0;
    got_cols.delete();
    send_done_col = -1; stall_valid = 0; stall_hold_bad = 0;
    issue(2'b10, b, 0, 0);
    for (int i = 0; i < 40; i++) begin
      stop = (got_cols.size() == stall_at && stalled < stall_len);
      if (stop) stalled++;
      tick();
      if (stop) begin
        if (B1_valid) stall_valid++;
        if (got_cols.size() > 0 && b1_u !== got_cols[got_cols.size()-1]) stall_hold_bad++;
      end
      if (B1_valid) got_cols.push_back(b1_u);
      if (done) begin send_done_col = got_cols.size(); break; end
    end
    stop = 1'b0;
  endtask

  function automatic logic [LW-1:0] col_exp(input int dx, input int c, input int first,
                                           input int step);
    logic [LW-1:0] v;
    v = '0;
    for (int r = 0; r < dx; r++) v[r*VS +: VS] = VS'(first + (c * dx + r) * step);
    return v;
  endfunction

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_B1_valid", B1_valid, 1'b0);
    check("rst_B1", b1_u, '0);
    check("rst_done_err", {done, err}, 2'b00);
    rst_n = 1'b1;
    chk_on = 1'b1;
    tick();

    // 2x3 load into buffer 3, then replay its three columns
    do_load(3, 2, 3, 1, 1, done_at);
    check("load23_done_at", done_at, 6);
    check("load23_busy_after", busy, 1'b0);
    check("load23_dim_x_out", dim_x_out, 8'd2);
    check("load23_dim_y_out", dim_y_out, 8'd3);
    do_send(3, -1, 0);
    check("send23_ncols", got_cols.size(), 3);
    if (got_cols.size() == 3) begin
      check("send23_col0", got_cols[0], 80'h0201);
      check("send23_col1", got_cols[1], 80'h0403);
      check("send23_col2", got_cols[2], 80'h0605);
    end
    check("send23_done_col", send_done_col, 3);

    // clear buffer 3, then a send to it is rejected
    issue(2'b11, 3, 0, 0);
    n = 0;
    while (!done && n < 20) begin tick(); n++; end
    check("clear_cycles", n, MS);
    issue(2'b10, 3, 0, 0);
    check("send_cleared_err", err, 1'b1);
    check("send_cleared_busy", busy, 1'b0);
    check("cleared_dims", {dim_x_out, dim_y_out}, 16'h0000);

    // oversize load rejected, dimensions untouched
    issue(2'b01, 0, 11, 1);
    check("oversize_err", err, 1'b1);
    check("oversize_busy", busy, 1'b0);
    tick();
    check("oversize_err_pulse", err, 1'b0);
    check("oversize_dim_x_out", dim_x_out, 8'd0);

    // 3x3 with a two-cycle stall after the first column
    do_load(5, 3, 3, -40, 9, done_at);
    check("load33_done_at", done_at, 9);
    do_send(5, 1, 2);
    check("stall_ncols", got_cols.size(), 3);
    check("stall_valid_low", stall_valid, 0);
    check("stall_hold", stall_hold_bad, 0);
    if (got_cols.size() == 3) begin
      check("stall_col0", got_cols[0], col_exp(3, 0, -40, 9));
      check("stall_col1", got_cols[1], col_exp(3, 1, -40, 9));
      check("stall_col2", got_cols[2], col_exp(3, 2, -40, 9));
    end
    check("stall_done_col", send_done_col, 3);

    // index range edge and a full 10x10 load
    issue(2'b01, 16, 2, 2);
    check("buf16_err", err, 1'b1);
    do_load(15, 10, 10, 0, 1, done_at);
    check("load1010_done_at", done_at, 100);
    do_send(15, -1, 0);
    check("send1010_ncols", got_cols.size(), 10);
    if (got_cols.size() == 10) check("send1010_col9", got_cols[9], col_exp(10, 9, 0, 1));
    check("send1010_done_col", send_done_col, 10);

    // reset in the middle of a 4x4 load
    issue(2'b01, 7, 4, 4);
    done_seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      A = VS'(i);
      tick();
      if (done) done_seen = 1'b1;
    end
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_outs", {B1_valid, done, err}, 3'b000);
    check("midrst_dims", {dim_x_out, dim_y_out}, 16'h0000);
    check("midrst_B1", b1_u, '0);
    check("midrst_no_done", done_seen, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    do_load(7, 2, 2, 3, -5, done_at);
    check("post_rst_done_at", done_at, 4);
    do_send(7, -1, 0);
    check("post_rst_ncols", got_cols.size(), 2);
    if (got_cols.size() == 2) check("post_rst_col1", got_cols[1], col_exp(2, 1, 3, -5));

    // randomized traffic, checked every cycle against the model
    for (int i = 0; i < 4000; i++) begin
      int sel;
      sel = $urandom_range(0, 99);
      stop = ($urandom_range(0, 9) == 0);
      cmd = (sel < 80) ? 2'b00 : (sel < 89) ? 2'b01 : (sel < 97) ? 2'b10 : 2'b11;
      buffer = BW'($urandom_range(0, 17));
      dim_x_in = 8'($urandom_range(0, 11));
      dim_y_in = 8'($urandom_range(0, 11));
      A = VS'($urandom);
      if (i == 2000) begin
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
      tick();
    end
    cmd = 2'b00; stop = 1'b0;
    repeat (120) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/buffer_a_nx.md
BUFFER_A_NX -- requirements
Module: buffer_a_nx

Interface
REQ-001 SHALL have parameter VAR_SIZE, default 8: signed element width in bits.
REQ-002 SHALL have parameter MMU_SIZE, default 10: lanes per column and maximum rows/columns per buffer.
REQ-003 SHALL have parameter NUM_BUF, default 16: number of independent buffers.
REQ-004 SHALL have parameter BUF_W, default 5: buffer index width, at least clog2(NUM_BUF).
REQ-005 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-007 SHALL have port stop, input, 1: stall; freezes the operation in progress.
REQ-008 SHALL have port cmd, input, 2: 00 NONE, 01 LOAD, 10 SEND, 11 CLEAR.
REQ-009 SHALL have port buffer, input, BUF_W: target buffer index.
REQ-010 SHALL have port A, input, VAR_SIZE, signed: load data, one element per cycle.
REQ-011 SHALL have port dim_x_in, input, 8: rows of the matrix to be loaded.
REQ-012 SHALL have port dim_y_in, input, 8: columns of the matrix to be loaded.
REQ-013 SHALL have port B1, output, VAR_SIZE*MMU_SIZE, signed: column output; lane r occupies bits [r*VAR_SIZE +: VAR_SIZE].
REQ-014 SHALL have port B1_valid, output, 1: B1 holds a valid column.
REQ-015 SHALL have port busy, output, 1: state is not IDLE.
REQ-016 SHALL have port done, output, 1: one-cycle pulse on completion of LOAD, SEND or CLEAR.
REQ-017 SHALL have port err, output, 1: one-cycle pulse when a command is rejected.
REQ-018 SHALL have ports dim_x_out and dim_y_out, output, 8 each: stored dimensions of buffer[buffer], registered.

Function
REQ-019 SHALL implement FSM states IDLE, LOAD, SEND, CLEAR; storage is NUM_BUF x MMU_SIZE columns x MMU_SIZE rows of VAR_SIZE bits.
REQ-020 SHALL accept a command only in IDLE with cmd!=NONE and stop=0, latching the target buffer index and entering the command's state on the next edge.
REQ-021 SHALL reject a command and pulse err on the next cycle, staying in IDLE, when any of these holds:
- buffer >= NUM_BUF;
- LOAD with dim_x_in or dim_y_in equal to 0 or greater than MMU_SIZE;
- SEND to a buffer whose stored dim_y is 0.
REQ-022 SHALL store dim_x_in/dim_y_in as the target buffer's dimensions when LOAD is accepted; accepted CLEAR sets them to 0.
REQ-023 LOAD SHALL sample A on each non-stalled LOAD cycle into (row r, column c), starting at r=0,c=0, with r advancing fastest.
- r wraps to 0 at dim_x-1 and c increments.
- LOAD completes after element (dim_x-1, dim_y-1): dim_x*dim_y writes, then IDLE with done.
REQ-024 SEND SHALL step c from 0 to dim_y-1, one column per non-stalled cycle.
- B1 and B1_valid are registered: column c appears, with B1_valid=1, on the cycle after c is addressed.
- Lanes r >= stored dim_x read as 0.
- Returns to IDLE with done coincident with the last valid column.
REQ-025 CLEAR SHALL zero one column of the target buffer per non-stalled cycle for MMU_SIZE cycles, then return to IDLE with done.
REQ-026 stop=1 SHALL freeze the state, row and column pointers, suppress memory writes and force B1_valid=0 for that cycle.
- B1 holds its last value while stalled.
- stop=1 with cmd=CLEAR in any state SHALL abort to CLEAR of the latched buffer, restarting at column 0; no done is issued for the aborted operation.
REQ-027 B1 SHALL be 0 whenever B1_valid=0 outside a stall.
REQ-028 dim_x_out/dim_y_out SHALL update one cycle after buffer changes, and SHALL read 0 for an out-of-range index.
REQ-029 cmd SHALL be ignored outside IDLE, except for REQ-026.

Reset
REQ-030 rst_n low SHALL asynchronously force:
- state to IDLE;
- all pointers, all stored dimensions and the latched buffer index to 0;
- B1, B1_valid, busy, done, err, dim_x_out and dim_y_out to 0.
REQ-031 Memory contents need not be reset; REQ-024 masking and dims=0 make stale data unobservable.
REQ-032 Reset asserted mid-operation SHALL abandon the operation with no done pulse; the first command after release is accepted normally.

Verification
REQ-033 LOAD buf 3, 2x3, A=1..6, then SEND buf 3 -> three valid columns, lanes0..1 = (1,2),(3,4),(5,6), lanes2..9 = 0; done with third column.
REQ-034 LOAD buf 0 with dim_x_in=11 -> err one cycle, busy stays 0, dim_x_out for buf 0 stays 0.
REQ-035 SEND 3x3 with stop=1 for 2 cycles after first column -> B1_valid low 2 cycles, no column skipped or repeated, total 3 valid.
REQ-036 CLEAR buf 3 after REQ-033 load, then SEND buf 3 -> err (dim_y=0); dim_x_out=dim_y_out=0 for buf 3.
REQ-037 rst_n low in the middle of a 4x4 LOAD -> outputs 0 immediately (before the next edge), no done; a later LOAD/SEND round trip succeeds.
REQ-038 buffer=15 valid, buffer=16 -> err; LOAD buf 15 at 10x10 (100 cycles) -> done exactly on the 100th write cycle.
